instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 49 ++++
 rtl/instr_encoder_if.sv | 37 +++
 rtl/instr_encoder_imm_range_check.sv | 14 +
 rtl/instr_encoder.sv | 141 ++++++++++++++
 tb/tb_instr_encoder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the instruction encoder: widths, opcode names,
// FSM state encoding and the memory-word packing helper.
package instr_encoder_pkg;

  localparam int INST_W = 8;
  localparam int OPC_W  = 4;
  localparam int ADDR_W = 8;
  localparam int IMM_W  = 8;
  localparam int RSEL_W = 2;
  localparam int CNT_W  = 8;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP = 4'h0,
    OPC_LDI = 4'h1,
    OPC_ADD = 4'h2,
    OPC_ADI = 4'h3,
    OPC_SUB = 4'h4,
    OPC_AND = 4'h5,
    OPC_OR  = 4'h6,
    OPC_XOR = 4'h7,
    OPC_SHL = 4'h8,
    OPC_SHR = 4'h9,
    OPC_MOV = 4'hA,
    OPC_CMP = 4'hB,
    OPC_JMP = 4'hC,
    OPC_JZ  = 4'hD,
    OPC_JNZ = 4'hE,
    OPC_HLT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // 4-bit format keeps the low immediate nibble; 2-bit format packs rsel above imm[1:0].
  function automatic logic [INST_W-1:0] pack_word(
    input logic [OPC_W-1:0]  opc,
    input logic [IMM_W-1:0]  imm,
    input logic              isim4,
    input logic [RSEL_W-1:0] rsel
  );
    if (isim4) pack_word = {opc, imm[3:0]};
    else       pack_word = {opc, rsel, imm[1:0]};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-input handshake plus instruction-memory write port and status of the encoder.
interface instr_encoder_if;

  // Handshake: a transfer happens on a rising clk edge where in_valid && in_ready;
  // the fields must be stable while in_valid is high, and in_ready never depends on in_valid.
  logic                                    in_valid;
  logic                                    in_ready;
  logic [instr_encoder_pkg::OPC_W-1:0]     opcode;
  logic [instr_encoder_pkg::IMM_W-1:0]     imm8;
  logic                                    isim4;
  logic [instr_encoder_pkg::RSEL_W-1:0]    rsel;
  logic                                    prog_last;

  logic                                    mem_we;
  logic [instr_encoder_pkg::ADDR_W-1:0]    mem_addr;
  logic [instr_encoder_pkg::INST_W-1:0]    mem_wdata;

  logic                                    done;
  logic                                    full;
  logic                                    err;
  logic [instr_encoder_pkg::CNT_W-1:0]     err_count;
  logic [instr_encoder_pkg::INST_W-1:0]    checksum;
  instr_encoder_pkg::state_e               state_dbg;

  modport master (
    output in_valid, opcode, imm8, isim4, rsel, prog_last,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  done, full, err, err_count, checksum, state_dbg
  );

  modport slave (
    input  in_valid, opcode, imm8, isim4, rsel, prog_last,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output done, full, err, err_count, checksum, state_dbg
  );

endinterface

// File: rtl/instr_encoder_imm_range_check.sv
// Combinational test of whether a signed 8-bit immediate fits the selected format.
module imm_range_check (
  input  logic [7:0] imm8,
  input  logic       isim4,
  output logic       fits
);

  // A value fits when every bit above the kept field equals the field's sign bit.
  always_comb begin
    if (isim4) fits = (&imm8[7:3]) | ~(|imm8[7:3]);
    else       fits = (&imm8[7:1]) | ~(|imm8[7:1]);
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts fields, range-checks the immediate and writes packed words
// to sequential memory addresses. Define INSTR_ENC_CHECKSUM_EN for a running XOR checksum.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  instr_encoder_if.slave bus
);

  state_e              state_q, state_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [IMM_W-1:0]    imm_q, imm_d;
  logic                isim4_q, isim4_d;
  logic [RSEL_W-1:0]   rsel_q, rsel_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                full_q, full_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic                fits;
  logic                ready;
  logic                we;
  logic [INST_W-1:0]   wdata;

  imm_range_check u_range (
    .imm8  (imm_q),
    .isim4 (isim4_q),
    .fits  (fits)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      opc_q     <= '0;
      imm_q     <= '0;
      isim4_q   <= 1'b0;
      rsel_q    <= '0;
      last_q    <= 1'b0;
      ptr_q     <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      imm_q     <= imm_d;
      isim4_q   <= isim4_d;
      rsel_q    <= rsel_d;
      last_q    <= last_d;
      ptr_q     <= ptr_d;
      full_q    <= full_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    imm_d     = imm_q;
    isim4_d   = isim4_q;
    rsel_d    = rsel_q;
    last_d    = last_q;
    ptr_d     = ptr_q;
    full_d    = full_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    ready     = 1'b0;
    we        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          opc_d   = bus.opcode;
          imm_d   = bus.imm8;
          isim4_d = bus.isim4;
          rsel_d  = bus.rsel;
          last_d  = bus.prog_last;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (fits) begin
          state_d = ST_WRITE;
        end else begin
          err_d = 1'b1;
          if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        we = 1'b1;
        // The last address is written once and then the encoder parks in DONE.
        if (ptr_q == {ADDR_W{1'b1}}) full_d = 1'b1;
        else                         ptr_d  = ptr_q + 8'd1;
        if (last_q || (ptr_q == {ADDR_W{1'b1}})) state_d = ST_DONE;
        else                                     state_d = ST_IDLE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign wdata = we ? pack_word(opc_q, imm_q, isim4_q, rsel_q) : '0;

`ifdef INSTR_ENC_CHECKSUM_EN
  logic [INST_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (we) csum_d = csum_q ^ wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign bus.checksum = csum_q;
`else
  assign bus.checksum = '0;
`endif

  assign bus.in_ready  = ready;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = ptr_q;
  assign bus.mem_wdata = wdata;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.full      = full_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_cnt_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: reference model feeds an expected-write queue that a
// negedge monitor drains; status is compared against the model at fixed points.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  logic [7:0] m_ptr, m_err_cnt, m_csum;
  logic       m_err, m_full, m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic fits_model(input logic [7:0] imm, input logic is4);
    if (is4) return ($signed(imm) >= -8) && ($signed(imm) <= 7);
    else     return ($signed(imm) >= -2) && ($signed(imm) <= 1);
  endfunction

  task automatic model_reset();
    m_ptr = 8'd0; m_err_cnt = 8'd0; m_csum = 8'd0;
    m_err = 1'b0; m_full = 1'b0; m_done = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_err"},       bus.err,       m_err);
    chk({tag, "_err_count"}, bus.err_count, m_err_cnt);
    chk({tag, "_full"},      bus.full,      m_full);
    chk({tag, "_done"},      bus.done,      m_done);
    chk({tag, "_addr"},      bus.mem_addr,  m_ptr);
`ifdef INSTR_ENC_CHECKSUM_EN
    chk({tag, "_checksum"},  bus.checksum,  m_csum);
`else
    chk({tag, "_checksum"},  bus.checksum,  8'd0);
`endif
  endtask

  // Update the model for an accepted instruction and queue the write it should produce.
  task automatic model_accept(input logic [3:0] opc, input logic [7:0] imm, input logic is4,
                              input logic [1:0] rs, input logic last, output logic fit);
    logic [7:0] w;
    fit = fits_model(imm, is4);
    w = is4 ? {opc, imm[3:0]} : {opc, rs, imm[1:0]};
    if (fit) begin
      exp_q.push_back({m_ptr, w});
      m_csum = m_csum ^ w;
      if (m_ptr == 8'hFF) begin
        m_full = 1'b1;
        m_done = 1'b1;
      end else begin
        m_ptr = m_ptr + 8'd1;
      end
      if (last) m_done = 1'b1;
    end else begin
      m_err = 1'b1;
      if (m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
    end
  endtask

  task automatic drive(input logic [3:0] opc, input logic [7:0] imm, input logic is4,
                       input logic [1:0] rs, input logic last);
    bus.in_valid  = 1'b1;
    bus.opcode    = opc;
    bus.imm8      = imm;
    bus.isim4     = is4;
    bus.rsel      = rs;
    bus.prog_last = last;
  endtask

  task automatic send(input logic [3:0] opc, input logic [7:0] imm, input logic is4,
                      input logic [1:0] rs, input logic last);
    int   waited;
    logic fit;
    drive(opc, imm, is4, rs, last);
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("in_ready_timeout", bus.in_ready, 1'b1);
      bus.in_valid = 1'b0;
      return;
    end
    model_accept(opc, imm, is4, rs, last, fit);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("we_in_check_cycle", bus.mem_we, 1'b0);
    @(negedge clk);
    chk("we_latency", bus.mem_we, fit);
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", bus.mem_we, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.mem_addr, e[15:8]);
        chk("wr_data", bus.mem_wdata, e[7:0]);
      end
    end
  end

  initial begin
    logic       fit;
    logic       is4;
    logic [3:0] r;
    logic [7:0] imm;

    bus.in_valid = 1'b0; bus.opcode = '0; bus.imm8 = '0;
    bus.isim4 = 1'b0; bus.rsel = '0; bus.prog_last = 1'b0;
    model_reset();

    // Reset state
    do_reset(3);
    @(negedge clk);
    chk("rst_in_ready",  bus.in_ready,  1'b1);
    chk("rst_mem_we",    bus.mem_we,    1'b0);
    chk("rst_mem_wdata", bus.mem_wdata, 8'd0);
    chk("rst_state",     bus.state_dbg, ST_IDLE);
    check_status("rst");

    // Both formats, then an out-of-range immediate
    send(4'h3, 8'hFD, 1'b1, 2'b00, 1'b0);
    send(4'hA, 8'hFF, 1'b0, 2'b01, 1'b0);
    send(4'h5, 8'h08, 1'b1, 2'b00, 1'b0);
    @(negedge clk);
    check_status("after_err");

    // Erroneous instruction flagged last must not finish the program
    send(4'h7, 8'h80, 1'b0, 2'b10, 1'b1);
    @(negedge clk);
    chk("err_last_in_ready", bus.in_ready, 1'b1);
    check_status("err_last");

    // Third valid instruction ends the program
    send(4'hC, 8'hF9, 1'b1, 2'b00, 1'b1);
    @(negedge clk);
    chk("done_in_ready", bus.in_ready, 1'b0);
    chk("done_state",    bus.state_dbg, ST_DONE);
    check_status("done");
    drive(4'h1, 8'h01, 1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("done_no_write", bus.mem_we, 1'b0);
    end
    bus.in_valid = 1'b0;
    chk("done_addr_held", bus.mem_addr, m_ptr);

    // Reset landing in the WRITE cycle aborts the operation
    do_reset(2);
    send(4'h2, 8'h40, 1'b0, 2'b00, 1'b0);
    send(4'h6, 8'h01, 1'b0, 2'b11, 1'b0);
    @(negedge clk);
    check_status("pre_abort");
    drive(4'h9, 8'hFE, 1'b0, 2'b01, 1'b0);
    model_accept(4'h9, 8'hFE, 1'b0, 2'b01, 1'b0, fit);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_we_in_write", bus.mem_we, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_mem_we",   bus.mem_we,   1'b0);
    chk("abort_in_ready", bus.in_ready, 1'b1);
    check_status("abort");

    // Fill the whole memory
    do_reset(2);
    for (int i = 0; i < 256; i++) begin
      is4 = 1'($urandom_range(0, 1));
      r   = 4'($urandom_range(0, 15));
      imm = is4 ? {{4{r[3]}}, r} : {{6{r[1]}}, r[1:0]};
      send(4'($urandom_range(0, 15)), imm, is4, 2'($urandom_range(0, 3)), 1'b0);
      if (i == 254) begin
        @(negedge clk);
        check_status("fill_254");
      end
    end
    @(negedge clk);
    chk("fill_in_ready", bus.in_ready, 1'b0);
    check_status("fill_end");

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
